// File: rtl/cntr_sched.sv
// Round-robin grant scheduler for four requesters with a counted grant window.
// Optional early window end on a dropped request: define CNTR_SCHED_ABORT_EN.
module cntr_sched #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [N-1:0] limit,
  output logic [3:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cntr_out
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N-1:0]      cntr_q, cntr_d;
  logic [N-1:0]      lim_q, lim_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;

  logic              win_vld_c;
  logic [PW-1:0]     win_idx_c;
  logic [PW-1:0]     cand_c;
  logic              abort_c;

  // First set request at ptr, ptr+1, ... wrapping modulo four.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c = ptr_q + PW'(i);
      if (!win_vld_c && req[cand_c]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_c;
      end
    end
  end

`ifdef CNTR_SCHED_ABORT_EN
  assign abort_c = ~req[win_q];
`else
  assign abort_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    cntr_d  = cntr_q;
    lim_d   = lim_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld_c) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << win_idx_c;
          cntr_d  = '0;
          lim_d   = limit;
          win_d   = win_idx_c;
        end
      end
      GRANT: begin
        // Counter only advances while below the captured limit, so it cannot wrap.
        if (abort_c || (cntr_q == lim_q)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          done_d  = 1'b1;
          ptr_d   = win_q + PW'(1);
        end else begin
          cntr_d = cntr_q + N'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == GRANT) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cntr_q  <= '0;
      lim_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cntr_q  <= cntr_d;
      lim_q   <= lim_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cntr_out = cntr_q;

endmodule

// File: tb/tb_cntr_sched.sv
// Scoreboard bench for cntr_sched: per-cycle expectations queued with the stimulus,
// compared at the falling edge. Abort behaviour follows CNTR_SCHED_ABORT_EN.
module tb_cntr_sched;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [N-1:0] limit;
  logic [3:0]   gnt;
  logic         busy;
  logic         done;
  logic [N-1:0] cntr_out;

  typedef struct {
    logic [3:0]   gnt;
    logic         done;
    logic         busy;
    logic         cchk;
    logic [N-1:0] cnt;
    logic [3:0]   req_nx;
    logic [N-1:0] lim_nx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  cntr_sched #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .limit    (limit),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .cntr_out (cntr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle, plus the inputs to drive right after sampling it.
  function automatic void push(logic [3:0] g, logic d, logic b, logic cc, logic [N-1:0] c,
                               logic [3:0] rn, logic [N-1:0] ln);
    exp_t e;
    e.gnt = g; e.done = d; e.busy = b; e.cchk = cc; e.cnt = c;
    e.req_nx = rn; e.lim_nx = ln;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; limit = 4'd3;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || done !== 1'b0 || busy !== 1'b0 || cntr_out !== 4'd0) begin
      failures++;
      $display("FAIL reset_hold: gnt=%b done=%b busy=%b cnt=%0d, want all zero",
               gnt, done, busy, cntr_out);
    end
    req = 4'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: gnt=%b done=%b busy=%b, want idle", gnt, done, busy);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    req = 4'b0100; limit = 4'd3;
    for (int c = 0; c < 4; c++) push(4'b0100, 1'b0, 1'b1, 1'b1, N'(c), 4'b0100, 4'd3);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd3, 4'b0000, 4'd3);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1111, 4'd0);
    // Pointer is now 3: with every request up, requester 3 must win next.
    push(4'b1000, 1'b0, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL basic: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [3:0] g;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req = 4'b1111; limit = 4'd1;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      push(g, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1111, 4'd1);
      push(g, 1'b0, 1'b1, 1'b1, 4'd1, 4'b1111, 4'd1);
      push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd1, (k == 4) ? 4'b0000 : 4'b1111, 4'd1);
      push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, (k == 4) ? 4'b0000 : 4'b1111, 4'd1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL round_robin: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  task automatic test_limit_zero();
    exp_t e;
    req = 4'b0001; limit = 4'd0;
    push(4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL limit_zero: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  task automatic test_limit_change();
    exp_t e;
    req = 4'b0010; limit = 4'd5;
    push(4'b0010, 1'b0, 1'b1, 1'b1, 4'd0, 4'b0010, 4'd5);
    push(4'b0010, 1'b0, 1'b1, 1'b1, 4'd1, 4'b0010, 4'd2);
    for (int c = 2; c < 6; c++) push(4'b0010, 1'b0, 1'b1, 1'b1, N'(c), 4'b0010, 4'd2);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd5, 4'b0000, 4'd2);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL limit_change: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  task automatic test_reset_mid_window();
    exp_t e;
    req = 4'b0001; limit = 4'd7;
    for (int c = 0; c < 3; c++) push(4'b0001, 1'b0, 1'b1, 1'b1, N'(c), 4'b0001, 4'd7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL reset_mid_pre: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || cntr_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: gnt=%b cnt=%0d busy=%b done=%b, want all zero",
               gnt, cntr_out, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_nodone: done=%b gnt=%b, want 0 and 0000", done, gnt);
    end
    // Pointer was cleared, so requester 0 wins on the first edge after release.
    reset = 1'b1; req = 4'b0001; limit = 4'd0;
    push(4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 4'd0);
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL reset_mid_resume: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    // Pointer is 1 here, so the lone request 2 wins.
    req = 4'b0100; limit = 4'd7;
    for (int c = 0; c < 3; c++) push(4'b0100, 1'b0, 1'b1, 1'b1, N'(c), 4'b0100, 4'd7);
    push(4'b0100, 1'b0, 1'b1, 1'b1, 4'd3, 4'b0000, 4'd7);
`ifdef CNTR_SCHED_ABORT_EN
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd3, 4'b0000, 4'd0);
`else
    for (int c = 4; c < 8; c++) push(4'b0100, 1'b0, 1'b1, 1'b1, N'(c), 4'b0000, 4'd7);
    push(4'b0000, 1'b1, 1'b1, 1'b1, 4'd7, 4'b0000, 4'd0);
`endif
    push(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (gnt !== e.gnt || done !== e.done || busy !== e.busy || (e.cchk && cntr_out !== e.cnt)) begin
        failures++;
        $display("FAIL abort: got gnt=%b done=%b busy=%b cnt=%0d, want gnt=%b done=%b busy=%b cnt=%0d",
                 gnt, done, busy, cntr_out, e.gnt, e.done, e.busy, e.cnt);
      end
      req = e.req_nx; limit = e.lim_nx;
    end
  endtask

  initial begin
    reset = 1'b0; req = 4'b0; limit = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_limit_zero();
    test_limit_change();
    test_reset_mid_window();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
